// File: rtl/br_amba_iso_ds_fsm.sv
// Purpose: isolates a downstream AXI subordinate by closing AR/AW and finishing owed W, then waits for B/R to drain.
// Latency: blocks assert 1 cycle after isolate_req is seen high; isolate_done 1 cycle after the registered counters read empty.
// Backpressure: block_* gate valid/ready at the downstream port; no path from any input to any output in the same cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   isolate_req           level request to isolate the downstream port
//   isolate_done          downstream drained and fully blocked
//   aw_hs, w_hs, w_last   post-gate AW / W handshakes (w_last qualifies w_hs)
//   b_hs, ar_hs           post-gate B / AR handshakes
//   r_hs, r_last          post-gate R handshake (r_last qualifies r_hs)
//   block_aw/w/ar         gate controls towards the isolation mux

module br_amba_iso_ds_fsm #(
    parameter int MaxOutstanding = 16,
    localparam int CountWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic isolate_req,
    output logic isolate_done,
    input  logic aw_hs,
    input  logic w_hs,
    input  logic w_last,
    input  logic b_hs,
    input  logic ar_hs,
    input  logic r_hs,
    input  logic r_last,
    output logic block_aw,
    output logic block_w,
    output logic block_ar
);

    generate
        if (MaxOutstanding < 1) begin : g_bad_param
            $error("MaxOutstanding must be >= 1");
        end
    endgenerate

    localparam logic [CountWidth-1:0] CntOne  = CountWidth'(1);
    localparam logic signed [CountWidth:0] OwedOne = (CountWidth + 1)'(1);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2
    } state_e;

    state_e state;
    state_e state_d;

    logic [CountWidth-1:0]   wr_cnt;
    logic [CountWidth-1:0]   wr_cnt_d;
    logic [CountWidth-1:0]   rd_cnt;
    logic [CountWidth-1:0]   rd_cnt_d;
    // Positive: AWs accepted whose W burst has not completed.
    // Negative: W bursts that completed ahead of their AW.
    logic signed [CountWidth:0] w_owed;
    logic signed [CountWidth:0] w_owed_d;
    logic                    w_in_burst;
    logic                    w_in_burst_d;

    logic r_done;
    logic w_done;
    logic owed_neg;
    logic owed_pos;
    logic drained;

    assign r_done   = r_hs & r_last;
    assign w_done   = w_hs & w_last;
    assign owed_neg = w_owed[CountWidth];
    assign owed_pos = !w_owed[CountWidth] && (w_owed != '0);
    assign drained  = (wr_cnt == '0) && (rd_cnt == '0) && (w_owed == '0) && !w_in_burst;

    // ------------------------------------------------------------------
    // Tracking counters: updated in every state so that traffic accepted
    // before or during the request cycle is accounted for.
    // ------------------------------------------------------------------
    always_comb begin
        wr_cnt_d = wr_cnt;
        case ({aw_hs, b_hs})
            2'b10:   wr_cnt_d = wr_cnt + CntOne;
            2'b01:   wr_cnt_d = wr_cnt - CntOne;
            default: wr_cnt_d = wr_cnt;
        endcase
    end

    always_comb begin
        rd_cnt_d = rd_cnt;
        case ({ar_hs, r_done})
            2'b10:   rd_cnt_d = rd_cnt + CntOne;
            2'b01:   rd_cnt_d = rd_cnt - CntOne;
            default: rd_cnt_d = rd_cnt;
        endcase
    end

    always_comb begin
        w_owed_d = w_owed;
        case ({aw_hs, w_done})
            2'b10:   w_owed_d = w_owed + OwedOne;
            2'b01:   w_owed_d = w_owed - OwedOne;
            default: w_owed_d = w_owed;
        endcase
    end

    always_comb begin
        w_in_burst_d = w_in_burst;
        if (w_hs) begin
            w_in_burst_d = !w_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            w_owed     <= '0;
            w_in_burst <= 1'b0;
        end else begin
            wr_cnt     <= wr_cnt_d;
            rd_cnt     <= rd_cnt_d;
            w_owed     <= w_owed_d;
            w_in_burst <= w_in_burst_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_NORMAL;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Once draining starts it always completes through
    // Isolated, even if the request is withdrawn meanwhile, so the
    // subordinate is never handed back half-drained.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            ST_NORMAL: begin
                if (isolate_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_ISOLATED;
                end
            end
            ST_ISOLATED: begin
                if (!isolate_req) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state and counters only.
    // During drain AW is reopened only to pair with W bursts that already
    // led, and W only for accepted AWs or to finish a burst in flight.
    // ------------------------------------------------------------------
    always_comb begin
        block_aw     = 1'b0;
        block_w      = 1'b0;
        block_ar     = 1'b0;
        isolate_done = 1'b0;
        case (state)
            ST_NORMAL: begin
                block_aw = 1'b0;
            end
            ST_DRAIN: begin
                block_ar = 1'b1;
                block_aw = !owed_neg;
                block_w  = !(owed_pos || w_in_burst);
            end
            ST_ISOLATED: begin
                block_aw     = 1'b1;
                block_w      = 1'b1;
                block_ar     = 1'b1;
                isolate_done = 1'b1;
            end
            default: begin
                block_aw = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    localparam logic [CountWidth-1:0]   CntMax  = CountWidth'(MaxOutstanding);
    localparam logic signed [CountWidth:0] OwedMax = (CountWidth + 1)'(MaxOutstanding);
    localparam logic signed [CountWidth:0] OwedMin = (CountWidth + 1)'(-MaxOutstanding);

    a_wr_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(aw_hs && !b_hs && (wr_cnt == CntMax)));
    a_wr_udf: assert property (@(posedge clk) disable iff (!rst_n)
        !(b_hs && !aw_hs && (wr_cnt == '0)));
    a_rd_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(ar_hs && !r_done && (rd_cnt == CntMax)));
    a_rd_udf: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_done && !ar_hs && (rd_cnt == '0)));
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_cnt <= CntMax) && (rd_cnt <= CntMax));
    a_owed_range: assert property (@(posedge clk) disable iff (!rst_n)
        (w_owed <= OwedMax) && (w_owed >= OwedMin));
    a_aw_blocked: assert property (@(posedge clk) disable iff (!rst_n)
        !(aw_hs && block_aw));
    a_ar_blocked: assert property (@(posedge clk) disable iff (!rst_n)
        !(ar_hs && block_ar));
    a_w_blocked: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_hs && block_w));
    a_state_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(state));
    a_done_empty: assert property (@(posedge clk) disable iff (!rst_n)
        isolate_done |-> ((wr_cnt == '0) && (rd_cnt == '0)));
`endif

endmodule

// File: tb/tb_br_amba_iso_ds_fsm.sv
// Purpose: directed self-checking bench for br_amba_iso_ds_fsm.
// Latency: one tick per driven cycle; outputs sampled 1 time unit after each rising edge.
// Backpressure: stimulus only issues handshakes on channels the DUT leaves open.

module tb_br_amba_iso_ds_fsm;

    logic clk;
    logic rst_n;
    logic isolate_req;
    logic isolate_done;
    logic aw_hs;
    logic w_hs;
    logic w_last;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic r_last;
    logic block_aw;
    logic block_w;
    logic block_ar;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_NORMAL   = 2'd0;
    localparam logic [1:0] S_DRAIN    = 2'd1;
    localparam logic [1:0] S_ISOLATED = 2'd2;

    br_amba_iso_ds_fsm #(.MaxOutstanding(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .isolate_req  (isolate_req),
        .isolate_done (isolate_done),
        .aw_hs        (aw_hs),
        .w_hs         (w_hs),
        .w_last       (w_last),
        .b_hs         (b_hs),
        .ar_hs        (ar_hs),
        .r_hs         (r_hs),
        .r_last       (r_last),
        .block_aw     (block_aw),
        .block_w      (block_w),
        .block_ar     (block_ar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected value packs {block_aw, block_w, block_ar, isolate_done}.
    task automatic chk_out(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, block_aw, block_w, block_ar, isolate_done}, {28'd0, exp});
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        check(tag, {30'd0, dut.state}, {30'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        aw_hs = 1'b0; w_hs = 1'b0; w_last = 1'b0; b_hs = 1'b0;
        ar_hs = 1'b0; r_hs = 1'b0; r_last = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        isolate_req = 1'b0;
        idle_inputs();
        #1;
        chk_out("reset_outputs", 4'b0000);
        check("reset_wr_cnt", dut.wr_cnt, 0);
        check("reset_rd_cnt", dut.rd_cnt, 0);
        check("reset_w_owed", dut.w_owed, 0);
        chk_state("reset_state", S_NORMAL);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("normal_idle", 4'b0000);

        // ---------------- Idle isolate ----------------
        isolate_req = 1'b1;
        tick();
        chk_state("idle_drain_state", S_DRAIN);
        chk_out("idle_drain_out", 4'b1110);
        tick();
        chk_state("idle_iso_state", S_ISOLATED);
        chk_out("idle_iso_out", 4'b1111);
        tick(); tick(); tick();
        chk_out("idle_iso_hold", 4'b1111);
        isolate_req = 1'b0;
        tick();
        chk_out("idle_release_out", 4'b0000);
        chk_state("idle_release_state", S_NORMAL);

        // ---------------- Read drain ----------------
        ar_hs = 1'b1;
        tick(); tick(); tick();
        ar_hs = 1'b0;
        check("rd_three_ar", dut.rd_cnt, 3);
        isolate_req = 1'b1;
        tick();
        chk_out("rd_drain_out", 4'b1110);
        r_hs = 1'b1; r_last = 1'b0;
        tick();
        check("rd_nonlast_no_dec", dut.rd_cnt, 3);
        r_last = 1'b1;
        tick();
        check("rd_cnt_2", dut.rd_cnt, 2);
        tick();
        check("rd_cnt_1", dut.rd_cnt, 1);
        tick();
        r_hs = 1'b0; r_last = 1'b0;
        check("rd_cnt_0", dut.rd_cnt, 0);
        chk_out("rd_not_done_yet", 4'b1110);
        tick();
        chk_out("rd_done", 4'b1111);
        isolate_req = 1'b0;
        tick();
        chk_out("rd_release", 4'b0000);

        // ---------------- AW leads W ----------------
        aw_hs = 1'b1;
        tick(); tick();
        aw_hs = 1'b0;
        check("awl_wr_cnt", dut.wr_cnt, 2);
        check("awl_owed", dut.w_owed, 2);
        isolate_req = 1'b1;
        tick();
        chk_out("awl_drain_out", 4'b1010);
        for (int b = 0; b < 2; b++) begin
            w_hs = 1'b1; w_last = 1'b0;
            tick(); tick(); tick();
            w_last = 1'b1;
            tick();
        end
        w_hs = 1'b0; w_last = 1'b0;
        check("awl_owed_zero", dut.w_owed, 0);
        chk_out("awl_w_closed", 4'b1110);
        b_hs = 1'b1;
        tick();
        check("awl_wr_cnt_1", dut.wr_cnt, 1);
        chk_out("awl_wait_b", 4'b1110);
        tick();
        b_hs = 1'b0;
        chk_out("awl_b_drained_not_done", 4'b1110);
        tick();
        chk_out("awl_done", 4'b1111);
        isolate_req = 1'b0;
        tick();
        chk_out("awl_release", 4'b0000);

        // ---------------- W leads AW ----------------
        w_hs = 1'b1; w_last = 1'b0;
        tick();
        check("wla_in_burst", {31'd0, dut.w_in_burst}, 1);
        tick(); tick();
        w_last = 1'b1;
        tick();
        w_hs = 1'b0; w_last = 1'b0;
        check("wla_owed_neg", dut.w_owed, -1);
        check("wla_burst_clear", {31'd0, dut.w_in_burst}, 0);
        isolate_req = 1'b1;
        tick();
        chk_out("wla_aw_open", 4'b0110);
        aw_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        check("wla_owed_zero", dut.w_owed, 0);
        chk_out("wla_aw_closed", 4'b1110);
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        chk_out("wla_b_not_done", 4'b1110);
        tick();
        chk_out("wla_done", 4'b1111);
        isolate_req = 1'b0;
        tick();
        chk_out("wla_release", 4'b0000);

        // ---------------- Simultaneous events ----------------
        ar_hs = 1'b1;
        tick();
        r_hs = 1'b1; r_last = 1'b1;
        tick();
        check("sim_rd_inc_dec", dut.rd_cnt, 1);
        ar_hs = 1'b0;
        tick();
        r_hs = 1'b0; r_last = 1'b0;
        check("sim_rd_zero", dut.rd_cnt, 0);
        aw_hs = 1'b1;
        tick();
        b_hs = 1'b1;
        tick();
        aw_hs = 1'b0; b_hs = 1'b0;
        check("sim_wr_inc_dec", dut.wr_cnt, 1);
        check("sim_owed_2", dut.w_owed, 2);
        isolate_req = 1'b1;
        tick();
        isolate_req = 1'b0;
        chk_out("sim_drain_out", 4'b1010);
        w_hs = 1'b1; w_last = 1'b1;
        tick(); tick();
        w_hs = 1'b0; w_last = 1'b0;
        chk_state("sim_still_drain", S_DRAIN);
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        chk_state("sim_drain_no_abort", S_DRAIN);
        tick();
        chk_state("sim_reach_iso", S_ISOLATED);
        chk_out("sim_iso_out", 4'b1111);
        tick();
        chk_state("sim_back_normal", S_NORMAL);
        chk_out("sim_normal_out", 4'b0000);

        // ---------------- Reset mid-drain ----------------
        aw_hs = 1'b1;
        tick(); tick();
        aw_hs = 1'b0;
        isolate_req = 1'b1;
        tick();
        chk_out("rst_pre_drain", 4'b1010);
        check("rst_pre_wr", dut.wr_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async_out", 4'b0000);
        check("rst_async_wr", dut.wr_cnt, 0);
        check("rst_async_owed", dut.w_owed, 0);
        chk_state("rst_async_state", S_NORMAL);
        isolate_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_state("rst_after_release", S_NORMAL);
        chk_out("rst_after_out", 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
